// File: rtl/memory_stage.sv
// memory_stage: Y86 memory stage with a 1024-byte little-endian data memory.
//
// Accepts one instruction per cycle through a valid/ready handshake, performs
// the 8-byte load or store the instruction calls for, and registers a
// write-back bundle one cycle later. Any non-AOK status makes the stage halt
// (in_ready stays low) until reset; the offending bundle is still delivered.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   icode, rA, rB       instruction code and register IDs
//   valE, valA, valP    ALU result, register A value, next PC
//   out_valid/out_ready write-back handshake
//   out_icode, out_rA, out_rB, out_valE, out_valM   write-back bundle
//   stat                1=AOK 2=HLT 3=ADR 4=INS, registered with the bundle
//
// Build option: define DMEM_ALIGN_CHECK_EN to also treat a misaligned memory
// access (addr[2:0] != 0) as an address error.

module memory_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [3:0]  out_rA,
    output logic [3:0]  out_rB,
    output logic [63:0] out_valE,
    output logic [63:0] out_valM,
    output logic [2:0]  stat
);

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    // Highest start address whose 8-byte access still fits in memory.
    localparam logic [63:0] MaxAddr = 64'd1016;

    logic [7:0]  mem_q [1024];

    logic        out_valid_q, out_valid_d;
    logic        halted_q, halted_d;
    logic [3:0]  out_icode_q, out_icode_d;
    logic [3:0]  out_ra_q, out_ra_d;
    logic [3:0]  out_rb_q, out_rb_d;
    logic [63:0] out_vale_q, out_vale_d;
    logic [63:0] out_valm_q, out_valm_d;
    logic [2:0]  stat_q, stat_d;

    logic        is_wr, is_rd, is_mem;
    logic [63:0] addr;
    logic        addr_err;
    logic [9:0]  idx;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [2:0]  new_stat;
    logic        accept;
    logic        we;

    // Decode and address generation.
    always_comb begin
        is_wr  = (icode == 4'h4) || (icode == 4'h8) || (icode == 4'hA);
        is_rd  = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
        is_mem = is_wr || is_rd;
        // popq/ret read from the stack pointer value carried in valA.
        addr   = ((icode == 4'h9) || (icode == 4'hB)) ? valA : valE;
`ifdef DMEM_ALIGN_CHECK_EN
        addr_err = is_mem && ((addr > MaxAddr) || (addr[2:0] != 3'd0));
`else
        addr_err = is_mem && (addr > MaxAddr);
`endif
        idx    = addr[9:0];
        // call pushes the return address; rmmovq/pushq store valA.
        wdata  = (icode == 4'h8) ? valP : valA;

        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem_q[idx + 10'(i)];
        end

        if (icode == 4'h0) begin
            new_stat = StatHlt;
        end else if (icode > 4'hB) begin
            new_stat = StatIns;
        end else if (addr_err) begin
            new_stat = StatAdr;
        end else begin
            new_stat = StatAok;
        end
    end

    assign in_ready = !halted_q && (!out_valid_q || out_ready);
    // Inputs are ignored entirely while reset is asserted.
    assign accept   = in_valid && in_ready && !rst;
    assign we       = accept && is_wr && !addr_err;

    // Bundle next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        out_icode_d = out_icode_q;
        out_ra_d    = out_ra_q;
        out_rb_d    = out_rb_q;
        out_vale_d  = out_vale_q;
        out_valm_d  = out_valm_q;
        stat_d      = stat_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_icode_d = icode;
            out_ra_d    = rA;
            out_rb_d    = rB;
            out_vale_d  = valE;
            out_valm_d  = (is_rd && !addr_err) ? rdata : 64'd0;
            stat_d      = new_stat;
            if (new_stat != StatAok) begin
                halted_d = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            out_icode_q <= 4'd0;
            out_ra_q    <= 4'd0;
            out_rb_q    <= 4'd0;
            out_vale_q  <= 64'd0;
            out_valm_q  <= 64'd0;
            stat_q      <= StatAok;
        end else begin
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            out_icode_q <= out_icode_d;
            out_ra_q    <= out_ra_d;
            out_rb_q    <= out_rb_d;
            out_vale_q  <= out_vale_d;
            out_valm_q  <= out_valm_d;
            stat_q      <= stat_d;
        end
    end

    // Memory is not reset; the write commits at the accept edge so a read
    // accepted on the following cycle already sees the new bytes.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[idx + 10'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign out_rA    = out_ra_q;
    assign out_rB    = out_rb_q;
    assign out_valE  = out_vale_q;
    assign out_valM  = out_valm_q;
    assign stat      = stat_q;

endmodule
